// File: rtl/lifo_fifo_pkg.sv
// ---------------------------------------------------------------------------
// lifo_fifo_pkg
// Shared types for the lifo_fifo_top storage front-end:
//   opcode_e      - LIFO/FIFO command encoding on the opcode port
//   sel_e         - decoded target of the current command
//   store_mode_e  - ordering mode of a word_store instance
//   decode_sel()  - fixed-priority select decode (buffer > LIFO > FIFO)
// ---------------------------------------------------------------------------
package lifo_fifo_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_CLR  = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'b00,
    SEL_BUF  = 2'b01,
    SEL_LIFO = 2'b10,
    SEL_FIFO = 2'b11
  } sel_e;

  typedef enum logic {
    MODE_LIFO = 1'b0,
    MODE_FIFO = 1'b1
  } store_mode_e;

  // Several enables may be set at once; the buffer wins, then the LIFO.
  function automatic sel_e decode_sel(input logic en_buf,
                                      input logic en_lifo,
                                      input logic en_fifo);
    sel_e sel;
    if (en_buf)       sel = SEL_BUF;
    else if (en_lifo) sel = SEL_LIFO;
    else if (en_fifo) sel = SEL_FIFO;
    else              sel = SEL_NONE;
    return sel;
  endfunction

endpackage

// File: rtl/lifo_fifo_top_word_store.sv
// ---------------------------------------------------------------------------
// word_store
// Small word storage that behaves either as a stack (MODE_LIFO) or as a
// circular queue (MODE_FIFO).
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   push, pop, clear  one-cycle command strobes (at most one set per cycle)
//   wr_data           word stored on push
//   rd_data           word that the next pop returns (valid when !empty)
//   full, empty       occupancy status, combinational from the count
// Push while full and pop while empty are ignored. Clear only resets the
// occupancy; stored words are left in place and become unreachable.
// ---------------------------------------------------------------------------
module word_store
  import lifo_fifo_pkg::*;
#(
  parameter int          DEPTH = 4,
  parameter int          DW    = 32,
  parameter store_mode_e MODE  = MODE_FIFO
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  localparam int CW = $clog2(DEPTH + 1);  // count spans 0..DEPTH
  localparam int AW = $clog2(DEPTH);      // entry index

  logic [DW-1:0] mem [DEPTH];
  logic [CW-1:0] count_reg;

  logic do_push;
  logic do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  generate
    if (MODE == MODE_LIFO) begin : g_lifo
      // The count doubles as the stack pointer: the next free slot is
      // mem[count] and the top of stack is mem[count-1].
      logic [CW-1:0] top_idx;
      assign top_idx = count_reg - CW'(1);
      assign rd_data = mem[top_idx[AW-1:0]];

      always_ff @(posedge clk) begin
        if (do_push) mem[count_reg[AW-1:0]] <= wr_data;
      end

      always_ff @(posedge clk) begin
        if (reset || clear) count_reg <= '0;
        else if (do_push)   count_reg <= count_reg + CW'(1);
        else if (do_pop)    count_reg <= count_reg - CW'(1);
      end
    end else begin : g_fifo
      logic [AW-1:0] wr_ptr_reg;
      logic [AW-1:0] rd_ptr_reg;

      // Explicit wrap so a non power-of-two depth also works.
      function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
      endfunction

      assign rd_data = mem[rd_ptr_reg];

      always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= wr_data;
      end

      always_ff @(posedge clk) begin
        if (reset || clear) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else if (do_push) begin
          wr_ptr_reg <= wrap_inc(wr_ptr_reg);
          count_reg  <= count_reg + CW'(1);
        end else if (do_pop) begin
          rd_ptr_reg <= wrap_inc(rd_ptr_reg);
          count_reg  <= count_reg - CW'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/lifo_fifo_top.sv
// ---------------------------------------------------------------------------
// lifo_fifo_top
// Random-access word buffer feeding one LIFO and one FIFO, with a single
// registered data output shared by buffer reads and pops.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   chip_en_buf/lifo/fifo            target select (buffer > LIFO > FIFO)
//   din, addr, r_w                   buffer write data, address, 1=write
//   valid                            command qualifier
//   opcode                           LIFO/FIFO command (nop/push/pop/clear)
//   dout                             registered read/pop data
//   full, empty                      status of LIFO when it is selected,
//                                    otherwise of the FIFO
// Pushes take their word from buf[addr] as sampled at the push edge.
// ---------------------------------------------------------------------------
module lifo_fifo_top
  import lifo_fifo_pkg::*;
#(
  parameter int DinLENGTH = 32,
  parameter int LIFO_Size = 4,
  parameter int WIDTH     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 chip_en_buf,
  input  logic                 chip_en_lifo,
  input  logic                 chip_en_fifo,
  input  logic [DinLENGTH-1:0] din,
  input  logic [WIDTH-1:0]     addr,
  input  logic                 r_w,
  input  logic                 valid,
  input  logic [1:0]           opcode,
  output logic [DinLENGTH-1:0] dout,
  output logic                 full,
  output logic                 empty
);

  localparam int BUF_WORDS = 1 << WIDTH;

  sel_e    sel;
  opcode_e op;

  logic buf_wr_en;
  logic buf_rd_en;
  logic lifo_cmd;
  logic fifo_cmd;

  logic [DinLENGTH-1:0] buf_words [BUF_WORDS];
  logic [DinLENGTH-1:0] buf_rd_word;

  logic [DinLENGTH-1:0] lifo_rd_data;
  logic [DinLENGTH-1:0] fifo_rd_data;
  logic                 lifo_full;
  logic                 lifo_empty;
  logic                 fifo_full;
  logic                 fifo_empty;

  logic [DinLENGTH-1:0] dout_reg;
  logic [DinLENGTH-1:0] dout_next;

  assign sel = decode_sel(chip_en_buf, chip_en_lifo, chip_en_fifo);
  assign op  = opcode_e'(opcode);

  // With no enable set the port still accepts buffer writes, so the host
  // can load words without first selecting the buffer. Reads need it.
  assign buf_wr_en = valid && r_w && ((sel == SEL_BUF) || (sel == SEL_NONE));
  assign buf_rd_en = valid && !r_w && (sel == SEL_BUF);
  assign lifo_cmd  = valid && (sel == SEL_LIFO);
  assign fifo_cmd  = valid && (sel == SEL_FIFO);

  // Buffer: one register per word so reset can clear every entry.
  generate
    for (genvar gi = 0; gi < BUF_WORDS; gi++) begin : g_buf
      logic [DinLENGTH-1:0] word_reg;

      always_ff @(posedge clk) begin
        if (reset)                                   word_reg <= '0;
        else if (buf_wr_en && (addr == WIDTH'(gi)))  word_reg <= din;
      end

      assign buf_words[gi] = word_reg;
    end
  endgenerate

  assign buf_rd_word = buf_words[addr];

  word_store #(
    .DEPTH (LIFO_Size),
    .DW    (DinLENGTH),
    .MODE  (MODE_LIFO)
  ) u_lifo (
    .clk     (clk),
    .reset   (reset),
    .push    (lifo_cmd && (op == OP_PUSH)),
    .pop     (lifo_cmd && (op == OP_POP)),
    .clear   (lifo_cmd && (op == OP_CLR)),
    .wr_data (buf_rd_word),
    .rd_data (lifo_rd_data),
    .full    (lifo_full),
    .empty   (lifo_empty)
  );

  word_store #(
    .DEPTH (LIFO_Size),
    .DW    (DinLENGTH),
    .MODE  (MODE_FIFO)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_cmd && (op == OP_PUSH)),
    .pop     (fifo_cmd && (op == OP_POP)),
    .clear   (fifo_cmd && (op == OP_CLR)),
    .wr_data (buf_rd_word),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Output register only moves on a real read or a successful pop.
  always_comb begin
    dout_next = dout_reg;
    if (buf_rd_en)
      dout_next = buf_rd_word;
    else if (lifo_cmd && (op == OP_POP) && !lifo_empty)
      dout_next = lifo_rd_data;
    else if (fifo_cmd && (op == OP_POP) && !fifo_empty)
      dout_next = fifo_rd_data;
  end

  always_ff @(posedge clk) begin
    if (reset) dout_reg <= '0;
    else       dout_reg <= dout_next;
  end

  assign dout  = dout_reg;
  assign full  = (sel == SEL_LIFO) ? lifo_full  : fifo_full;
  assign empty = (sel == SEL_LIFO) ? lifo_empty : fifo_empty;

endmodule

// File: tb/tb_lifo_fifo_top.sv
// ---------------------------------------------------------------------------
// tb_lifo_fifo_top
// Directed bench for lifo_fifo_top (DinLENGTH=32, LIFO_Size=4, WIDTH=4).
// Each scenario task drives commands and compares dout/full/empty with
// hand-computed values, sampling 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_lifo_fifo_top;

  logic        clk = 1'b0;
  logic        reset;
  logic        chip_en_buf;
  logic        chip_en_lifo;
  logic        chip_en_fifo;
  logic [31:0] din;
  logic [3:0]  addr;
  logic        r_w;
  logic        valid;
  logic [1:0]  opcode;
  logic [31:0] dout;
  logic        full;
  logic        empty;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lifo_fifo_top #(
    .DinLENGTH (32),
    .LIFO_Size (4),
    .WIDTH     (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .chip_en_buf  (chip_en_buf),
    .chip_en_lifo (chip_en_lifo),
    .chip_en_fifo (chip_en_fifo),
    .din          (din),
    .addr         (addr),
    .r_w          (r_w),
    .valid        (valid),
    .opcode       (opcode),
    .dout         (dout),
    .full         (full),
    .empty        (empty)
  );

  // ---------------- stimulus primitives ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic buf_write(input logic [3:0] a, input logic [31:0] d);
    chip_en_buf = 1'b0; chip_en_lifo = 1'b0; chip_en_fifo = 1'b0;
    valid = 1'b1; r_w = 1'b1; addr = a; din = d; opcode = 2'b00;
    step();
    valid = 1'b0;
    $display("txn buf_write addr=%0d data=%h", a, d);
  endtask

  task automatic buf_read(input logic [3:0] a);
    chip_en_buf = 1'b1; chip_en_lifo = 1'b0; chip_en_fifo = 1'b0;
    valid = 1'b1; r_w = 1'b0; addr = a; opcode = 2'b00;
    step();
    valid = 1'b0;
    $display("txn buf_read addr=%0d dout=%h", a, dout);
  endtask

  // Enables stay asserted afterwards so full/empty show the target.
  task automatic ls_cmd(input bit use_lifo, input logic [1:0] op, input logic [3:0] a);
    chip_en_buf = 1'b0; chip_en_lifo = use_lifo; chip_en_fifo = !use_lifo;
    valid = 1'b1; r_w = 1'b0; addr = a; opcode = op;
    step();
    valid = 1'b0;
    $display("txn %s op=%0d addr=%0d dout=%h full=%0b empty=%0b",
             use_lifo ? "lifo" : "fifo", op, a, dout, full, empty);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    valid = 1'b0;
    $display("txn reset dout=%h full=%0b empty=%0b", dout, full, empty);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    // Make dout and buf[5] non-zero so the reset has something to clear.
    buf_write(4'd5, 32'h0000_0055);
    buf_read(4'd5);
    // Reset coincides with a buffer write, which must lose.
    chip_en_buf = 1'b1; valid = 1'b1; r_w = 1'b1; addr = 4'd5; din = 32'h0000_0077;
    apply_reset();
    chip_en_buf = 1'b0;
    #1;
    checks++;
    if (dout !== 32'h0) begin failures++; $display("FAIL reset_dout: got %h expected %h", dout, 32'h0); end
    checks++;
    if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++;
    if (full !== 1'b0) begin failures++; $display("FAIL reset_full: got %b expected 0", full); end
    buf_read(4'd5);
    checks++;
    if (dout !== 32'h0) begin failures++; $display("FAIL reset_buf5: got %h expected %h", dout, 32'h0); end
  endtask

  task automatic test_buffer();
    buf_write(4'd3, 32'h1234_5678);
    buf_write(4'd5, 32'hABBA_ABBA);
    buf_write(4'd4, 32'h4563_2457);
    buf_read(4'd5);
    checks++;
    if (dout !== 32'hABBA_ABBA) begin failures++; $display("FAIL buf_read5: got %h expected %h", dout, 32'hABBA_ABBA); end
    // Idle cycle: dout must hold.
    chip_en_buf = 1'b0;
    step();
    checks++;
    if (dout !== 32'hABBA_ABBA) begin failures++; $display("FAIL buf_hold: got %h expected %h", dout, 32'hABBA_ABBA); end
    buf_read(4'd3);
    checks++;
    if (dout !== 32'h1234_5678) begin failures++; $display("FAIL buf_read3: got %h expected %h", dout, 32'h1234_5678); end
    buf_read(4'd4);
    checks++;
    if (dout !== 32'h4563_2457) begin failures++; $display("FAIL buf_read4: got %h expected %h", dout, 32'h4563_2457); end
  endtask

  task automatic test_fifo();
    logic [3:0]  push_addr [4];
    logic [31:0] exp_pop [4];
    push_addr = '{4'd5, 4'd3, 4'd4, 4'd0};
    exp_pop   = '{32'hABBA_ABBA, 32'h1234_5678, 32'h4563_2457, 32'hDEAD_BEEF};
    buf_write(4'd0, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) ls_cmd(1'b0, 2'b01, push_addr[i]);
    checks++;
    if (full !== 1'b0 || empty !== 1'b0) begin failures++; $display("FAIL fifo_3_status: got full=%b empty=%b expected full=0 empty=0", full, empty); end
    ls_cmd(1'b0, 2'b01, push_addr[3]);
    checks++;
    if (full !== 1'b1) begin failures++; $display("FAIL fifo_full: got %b expected 1", full); end
    ls_cmd(1'b0, 2'b01, 4'd3);  // dropped: queue already full
    checks++;
    if (full !== 1'b1) begin failures++; $display("FAIL fifo_full_after_extra: got %b expected 1", full); end
    // Selecting the (empty) LIFO switches the status outputs at once.
    chip_en_fifo = 1'b0; chip_en_lifo = 1'b1;
    #1;
    checks++;
    if (full !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL status_mux_lifo: got full=%b empty=%b expected full=0 empty=1", full, empty); end
    for (int i = 0; i < 4; i++) begin
      ls_cmd(1'b0, 2'b10, 4'd0);
      checks++;
      if (dout !== exp_pop[i]) begin failures++; $display("FAIL fifo_pop%0d: got %h expected %h", i, dout, exp_pop[i]); end
    end
    checks++;
    if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL fifo_empty: got full=%b empty=%b expected full=0 empty=1", full, empty); end
    ls_cmd(1'b0, 2'b10, 4'd0);  // pop on empty
    checks++;
    if (dout !== 32'hDEAD_BEEF) begin failures++; $display("FAIL fifo_pop_empty: got %h expected %h", dout, 32'hDEAD_BEEF); end
  endtask

  task automatic test_lifo();
    logic [3:0]  push_addr [4];
    logic [31:0] exp_pop [4];
    push_addr = '{4'd5, 4'd3, 4'd4, 4'd0};
    exp_pop   = '{32'hDEAD_BEEF, 32'h4563_2457, 32'h1234_5678, 32'hABBA_ABBA};
    for (int i = 0; i < 4; i++) ls_cmd(1'b1, 2'b01, push_addr[i]);
    checks++;
    if (full !== 1'b1) begin failures++; $display("FAIL lifo_full: got %b expected 1", full); end
    ls_cmd(1'b1, 2'b01, 4'd3);  // dropped: must not overwrite the top
    for (int i = 0; i < 4; i++) begin
      ls_cmd(1'b1, 2'b10, 4'd0);
      checks++;
      if (dout !== exp_pop[i]) begin failures++; $display("FAIL lifo_pop%0d: got %h expected %h", i, dout, exp_pop[i]); end
    end
    checks++;
    if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL lifo_empty: got full=%b empty=%b expected full=0 empty=1", full, empty); end
  endtask

  task automatic test_fifo_wrap();
    logic [31:0] exp_pop [4];
    exp_pop = '{32'h4563_2457, 32'hDEAD_BEEF, 32'hABBA_ABBA, 32'h1234_5678};
    ls_cmd(1'b0, 2'b01, 4'd5);
    ls_cmd(1'b0, 2'b01, 4'd3);
    ls_cmd(1'b0, 2'b01, 4'd4);
    ls_cmd(1'b0, 2'b10, 4'd0);
    checks++;
    if (dout !== 32'hABBA_ABBA) begin failures++; $display("FAIL wrap_pop_a: got %h expected %h", dout, 32'hABBA_ABBA); end
    ls_cmd(1'b0, 2'b10, 4'd0);
    checks++;
    if (dout !== 32'h1234_5678) begin failures++; $display("FAIL wrap_pop_b: got %h expected %h", dout, 32'h1234_5678); end
    ls_cmd(1'b0, 2'b01, 4'd0);
    ls_cmd(1'b0, 2'b01, 4'd5);
    ls_cmd(1'b0, 2'b01, 4'd3);
    checks++;
    if (full !== 1'b1) begin failures++; $display("FAIL wrap_full: got %b expected 1", full); end
    for (int i = 0; i < 4; i++) begin
      ls_cmd(1'b0, 2'b10, 4'd0);
      checks++;
      if (dout !== exp_pop[i]) begin failures++; $display("FAIL wrap_pop%0d: got %h expected %h", i, dout, exp_pop[i]); end
    end
    checks++;
    if (empty !== 1'b1) begin failures++; $display("FAIL wrap_empty: got %b expected 1", empty); end
  endtask

  task automatic test_reset_mid_and_clear();
    ls_cmd(1'b1, 2'b01, 4'd5);
    ls_cmd(1'b1, 2'b01, 4'd3);
    apply_reset();
    chip_en_lifo = 1'b1; chip_en_fifo = 1'b0;
    #1;
    checks++;
    if (empty !== 1'b1) begin failures++; $display("FAIL mid_reset_empty: got %b expected 1", empty); end
    checks++;
    if (dout !== 32'h0) begin failures++; $display("FAIL mid_reset_dout: got %h expected %h", dout, 32'h0); end
    ls_cmd(1'b1, 2'b10, 4'd0);
    checks++;
    if (dout !== 32'h0) begin failures++; $display("FAIL mid_reset_pop: got %h expected %h", dout, 32'h0); end
    // Clear on a non-empty FIFO.
    buf_write(4'd1, 32'h1111_1111);
    buf_write(4'd2, 32'h2222_2222);
    ls_cmd(1'b0, 2'b01, 4'd1);
    ls_cmd(1'b0, 2'b01, 4'd2);
    ls_cmd(1'b0, 2'b10, 4'd0);
    checks++;
    if (dout !== 32'h1111_1111) begin failures++; $display("FAIL clr_pre_pop: got %h expected %h", dout, 32'h1111_1111); end
    ls_cmd(1'b0, 2'b11, 4'd0);
    checks++;
    if (empty !== 1'b1) begin failures++; $display("FAIL clr_empty: got %b expected 1", empty); end
    checks++;
    if (dout !== 32'h1111_1111) begin failures++; $display("FAIL clr_dout: got %h expected %h", dout, 32'h1111_1111); end
    ls_cmd(1'b0, 2'b10, 4'd0);
    checks++;
    if (dout !== 32'h1111_1111) begin failures++; $display("FAIL clr_pop_after: got %h expected %h", dout, 32'h1111_1111); end
  endtask

  initial begin
    reset = 1'b0; chip_en_buf = 1'b0; chip_en_lifo = 1'b0; chip_en_fifo = 1'b0;
    din = '0; addr = '0; r_w = 1'b0; valid = 1'b0; opcode = 2'b00;
    step();
    test_reset();
    test_buffer();
    test_fifo();
    test_lifo();
    test_fifo_wrap();
    test_reset_mid_and_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lifo_fifo_top.md
# lifo_fifo_top

Storage front-end that holds a small random-access word buffer plus one LIFO and one FIFO, all sharing a single data input and a single registered data output. Words are written into the buffer by address, then moved from the buffer into the LIFO or FIFO and popped out in stack or queue order. Sits between a host command port and a downstream word consumer; full/empty status reports the structure currently selected.

## Interface
- DinLENGTH, 32: data word width.
- LIFO_Size, 4: depth in words of the LIFO and of the FIFO; ≥ 2.
- WIDTH, 4: buffer address width; the buffer holds 2^WIDTH words.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- chip_en_buf  in  1  select buffer.
- chip_en_lifo  in  1  select LIFO.
- chip_en_fifo  in  1  select FIFO.
- din  in  DinLENGTH  write data.
- addr  in  WIDTH  buffer address.
- r_w  in  1  buffer access: 1 = write, 0 = read.
- valid  in  1  command qualifier; no state change when 0.
- opcode  in  2  LIFO/FIFO command: 00 nop, 01 push, 10 pop, 11 clear.
- dout  out  DinLENGTH  registered read/pop data.
- full  out  1  selected structure full.
- empty  out  1  selected structure empty.

## Operation
- Select priority: chip_en_buf > chip_en_lifo > chip_en_fifo. No enable set means idle, except the default buffer write below.
- Buffer, either chip_en_buf=1 or no enable set, with valid=1:
  - r_w=1: buf[addr] <= din.
  - r_w=0 and chip_en_buf=1: dout <= buf[addr].
- LIFO or FIFO selected, with valid=1 (r_w and din are ignored):
  - 01 push: the entry receives buf[addr], sampled at the same edge.
  - 10 pop: dout <= the entry. LIFO returns the most recent push; FIFO returns the oldest.
  - 11 clear: occupancy goes to 0; dout is unchanged.
  - 00: no effect.
- Push when full: ignored. No overwrite, pointers unchanged.
- Pop when empty: ignored. dout holds its value.
- FIFO: read and write pointers wrap modulo LIFO_Size; a count register of width $clog2(LIFO_Size+1) drives full/empty.
- LIFO: stack pointer counts 0..LIFO_Size.
- full/empty source:
  - LIFO selected: report LIFO.
  - Otherwise: report FIFO, including when the buffer is selected or nothing is selected.
  - Combinational from the count registers: full = (count == LIFO_Size), empty = (count == 0).
- dout holds its last value whenever no read or pop occurs.

## Timing
- All state updates on the rising clk edge; inputs are sampled at that edge.
- Buffer read and pop: dout is valid after the edge that samples the command, i.e. 1-cycle latency.
- full/empty reflect the new count immediately after the push/pop edge. They also change combinationally when the chip enables change.
- Back-to-back commands every cycle are supported.
- Reset (while reset=1 at an edge):
  - dout=0, all buffer words=0, LIFO/FIFO pointers and counts=0.
  - Resulting outputs: empty=1, full=0.
  - Reset overrides any command in the same cycle.
  - Reset mid-sequence discards all stored data.

## Structure
- Package lifo_fifo_pkg: opcode enum (OP_NOP, OP_PUSH, OP_POP, OP_CLR) and select-priority encoding.
- One sub-module, word_store: parameterised depth/width storage with a MODE parameter (LIFO/FIFO). It exposes push, pop, clear, rd_data, full and empty. It is instantiated twice.
- The top level holds the buffer array, the select decode and the dout register.

## Test plan
All scenarios use DinLENGTH=32, LIFO_Size=4, WIDTH=4.
- Reset: hold reset 1 cycle → dout=0, empty=1, full=0; buffer read at addr 5 returns 0.
- Buffer: with no enable set, write 0x12345678@3, 0xABBAABBA@5, 0x45632457@4 → chip_en_buf read of addr 5 gives dout=0xABBAABBA one cycle later.
- FIFO: push addrs 5,3,4,0 (0xDEADBEEF written @0) → full=1 after 4th push. A 5th push is ignored. Pops give 0xABBAABBA, 0x12345678, 0x45632457, 0xDEADBEEF, then empty=1; a further pop keeps dout=0xDEADBEEF.
- LIFO: same pushes → pops give 0xDEADBEEF, 0x45632457, 0x12345678, 0xABBAABBA, then empty=1.
- FIFO wrap: push 3, pop 2, push 3 → full=1; pops return the remaining word and then the new ones in push order.
- Reset mid-operation: 2 LIFO pushes, then reset → empty=1, the next pop leaves dout=0. Clear (opcode 11) on a non-empty FIFO → empty=1, dout unchanged.
